rs_symbol_buffer: RTL
=====================

# rs_symbol_buffer

Parametrised single-clock symbol buffer for the RS decoder datapath. It holds received codeword symbols while syndrome, key-equation and Chien/Forney stages run, then returns them in arrival order to the error-correction adder. It generalises the fixed 31×5-bit shift FIFO in three ways: symbol width, codeword length and codeword depth are parameters; it supports zero-padding for shortened codes; and it adds valid/ready flow control with codeword-boundary markers.

## Interface
- SYM_W, 5, symbol width in bits (GF(2^SYM_W))
- N, 31, codeword length in symbols; 2 ≤ N ≤ 2^SYM_W−1
- WORDS, 2, buffer capacity in codewords; DEPTH = N*WORDS symbols, ≥ 2
- CW = clog2(DEPTH+1), occupancy counter width (derived, not overridable)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of contents and pointers; sticky flags kept
- in_valid  in  1  symbol offered
- in_pad  in  1  qualifies in_valid: store zero instead of in_sym (shortened-code padding)
- in_sym  in  SYM_W  received symbol
- in_ready  out  1  buffer can accept a symbol this cycle
- out_req  in  1  correction stage requests next symbol
- out_valid  out  1  out_sym holds the symbol requested last cycle
- out_sym  out  SYM_W  registered output symbol
- out_sof  out  1  with out_valid: symbol is index 0 of a codeword
- out_eof  out  1  with out_valid: symbol is index N−1 of a codeword
- count  out  CW  symbols stored
- word_avail  out  1  count ≥ N
- err_underflow  out  1  sticky: out_req while count = 0

## Operation
- Circular storage of DEPTH entries with write pointer wp and read pointer rp. Both count 0..DEPTH−1 and wrap explicitly to 0; DEPTH is generally not a power of two.
- Write: when in_valid && in_ready, mem[wp] ← (in_pad ? 0 : in_sym) and wp advances.
- in_ready = (count < DEPTH) && !reset && !flush.
- A write while full is impossible by construction. in_valid with in_ready = 0 is ignored; the producer holds its symbol.
- Read: when out_req && count > 0, then on the next edge out_sym ← mem[rp], out_valid ← 1, and rp advances. Otherwise out_valid ← 0 and out_sym holds its last value.
- Read index ri runs 0..N−1 and wraps. It increments on every accepted read. out_sof = (ri was 0) and out_eof = (ri was N−1) for the symbol being presented; both are 0 whenever out_valid = 0.
- Simultaneous accepted read and write: count unchanged. Accepted write only: count+1. Accepted read only: count−1.
- Reading while full frees no space in the same cycle: in_ready is computed from the current count.
- Read on empty: ignored, and err_underflow ← 1. It clears only on reset.
- flush: wp, rp, ri, count ← 0 and out_valid ← 0. Any write or read in that cycle is discarded. out_sym holds. err_underflow is unaffected.
- reset: as flush, plus out_sym ← 0 and err_underflow ← 0. Memory contents are not cleared.

## Timing
- Reset values: in_ready 0 while reset is high, 1 on the first cycle after; out_valid 0; out_sym 0; out_sof 0; out_eof 0; count 0; word_avail 0; err_underflow 0.
- Write-to-read: a symbol written at edge k raises count at edge k. out_req in cycle k+1 returns the symbol with out_valid at edge k+2.
- Read latency is 1 cycle from out_req to out_valid. Continuous out_req with count > 0 yields one symbol per cycle.
- Throughput is 1 write and 1 read per cycle, sustained, when 0 < count < DEPTH.
- count, word_avail and in_ready all reflect state after the most recent edge.
- Reset or flush asserted mid-codeword abandons the partial word. The next accepted write is treated as index 0.

## Test plan
- Reset, then write 31 symbols 1..31 (N=31, WORDS=2), then hold out_req for 31 cycles → out_sym = 1..31 in order, out_sof on 1, out_eof on 31, count returns to 0, word_avail high after the 31st write.
- Write 62 symbols → in_ready = 0 and count = 62. Extra in_valid for 3 cycles → count stays 62. Read 62 → data intact across the wp wrap.
- Continuous simultaneous write/read from count = 5 for 100 cycles → count stays 5, output is the input delayed by 5 accepted symbols, no gaps in out_valid.
- in_pad = 1 with in_sym = 5'h1F on symbols 0..3 → those read back as 0, others unchanged.
- out_req at count = 0 → out_valid = 0 and err_underflow = 1. Then flush → err_underflow stays 1. Then reset → err_underflow = 0.
- Flush after 17 writes of a codeword, then write a fresh 31-symbol word → read returns only the new word, out_sof on its first symbol.

Source files
------------

// File: rtl/rs_symbol_buffer.sv
// rs_symbol_buffer: circular codeword symbol buffer with pad, flow control and frame markers
module rs_symbol_buffer #(
    parameter int SYM_W = 5,
    parameter int N = 31,
    parameter int WORDS = 2,
    localparam int DEPTH = N * WORDS,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_pad,
    input  logic [SYM_W-1:0] in_sym,
    output logic             in_ready,
    input  logic             out_req,
    output logic             out_valid,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_sof,
    output logic             out_eof,
    output logic [CW-1:0]    count,
    output logic             word_avail,
    output logic             err_underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = $clog2(N);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] N_C = CW'(N);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [RW-1:0] RI_LAST = RW'(N - 1);
    logic [SYM_W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [RW-1:0] ri_q, ri_d;
    logic [CW-1:0] count_q, count_d;
    logic out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic err_q, err_d;
    logic [SYM_W-1:0] out_sym_q, out_sym_d;
    logic wr, rd;
    always_comb begin
        in_ready = (count_q < DEPTH_C) && !reset && !flush;
        wr = in_valid && in_ready;
        rd = out_req && (count_q != '0) && !flush;
        wp_d = flush ? '0 : wr ? (wp_q == PTR_LAST ? '0 : wp_q + 1'b1) : wp_q;
        rp_d = flush ? '0 : rd ? (rp_q == PTR_LAST ? '0 : rp_q + 1'b1) : rp_q;
        ri_d = flush ? '0 : rd ? (ri_q == RI_LAST ? '0 : ri_q + 1'b1) : ri_q;
        count_d = flush ? '0 : (wr && !rd) ? count_q + 1'b1 : (rd && !wr) ? count_q - 1'b1 : count_q;
        out_valid_d = rd;
        out_sof_d = rd && (ri_q == '0);
        out_eof_d = rd && (ri_q == RI_LAST);
        out_sym_d = rd ? mem_q[rp_q] : out_sym_q;
        err_d = err_q || (out_req && (count_q == '0));
    end
    always_ff @(posedge clock)
        if (wr) mem_q[wp_q] <= in_pad ? '0 : in_sym;
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
            ri_q <= '0;
            count_q <= '0;
            out_valid_q <= 1'b0;
            out_sof_q <= 1'b0;
            out_eof_q <= 1'b0;
            out_sym_q <= '0;
            err_q <= 1'b0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            ri_q <= ri_d;
            count_q <= count_d;
            out_valid_q <= out_valid_d;
            out_sof_q <= out_sof_d;
            out_eof_q <= out_eof_d;
            out_sym_q <= out_sym_d;
            err_q <= err_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_sym = out_sym_q;
    assign out_sof = out_sof_q;
    assign out_eof = out_eof_q;
    assign count = count_q;
    assign word_avail = count_q >= N_C;
    assign err_underflow = err_q;
endmodule
